// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, valid/ack holding register.
module uart_rx #(
  parameter int unsigned BAUD_DIVISOR = 868
) (
  input  logic       clk100,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int unsigned TIMER_W = 10;
  localparam int unsigned CNT_W   = 3;
  localparam logic [TIMER_W-1:0] FULL_BIT = TIMER_W'(BAUD_DIVISOR);
  localparam logic [TIMER_W-1:0] HALF_BIT = TIMER_W'(BAUD_DIVISOR >> 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t             state_q;
  logic               s1_q;
  logic               s2_q;
  logic [TIMER_W-1:0] timer_q;
  logic [CNT_W-1:0]   bitcnt_q;
  logic [7:0]         shift_q;
  logic [7:0]         data_q;
  logic               valid_q;
  logic               frame_err_q;
  logic               overrun_q;

  logic expiry;
  logic slot_free;

  assign expiry    = (timer_q == '0);
  // Holding register is free if empty or being acknowledged this cycle.
  assign slot_free = !valid_q || rx_ack;

  // Synchronizer, bit timer, framing FSM and holding register.
  always_ff @(posedge clk100) begin
    if (rst) begin
      state_q     <= IDLE;
      s1_q        <= 1'b1;
      s2_q        <= 1'b1;
      timer_q     <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      s1_q        <= rx;
      s2_q        <= s1_q;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      if (valid_q && rx_ack) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (!s2_q) begin
            state_q <= START;
            timer_q <= HALF_BIT;
          end
        end

        START: begin
          if (expiry) begin
            if (!s2_q) begin
              state_q  <= DATA;
              timer_q  <= FULL_BIT;
              bitcnt_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end

        DATA: begin
          if (expiry) begin
            shift_q  <= {s2_q, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 1'b1;
            timer_q  <= FULL_BIT;
            if (bitcnt_q == CNT_W'(7)) begin
              state_q <= STOP;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end

        STOP: begin
          if (expiry) begin
            timer_q <= FULL_BIT;
            if (s2_q) begin
              state_q <= IDLE;
              if (slot_free) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end

        BREAK: begin
          // Hold off until the line returns high so a break cannot retrigger.
          if (s2_q) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_busy      = (state_q != IDLE);
  assign rx_frame_err = frame_err_q;
  assign rx_overrun   = overrun_q;

endmodule
